mem_write_checker: RTL and testbench

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

---
 rtl/mwc_pkg.sv | 18 +
 rtl/mwc_exp_table.sv | 29 ++
 rtl/mem_write_checker.sv | 181 ++++++++++++++++++
 tb/tb_mem_write_checker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mwc_pkg.sv
// Shared types for the memory write checker: FSM states and failure codes.
package mwc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_XVAL     = 2'd3
  } fail_code_t;

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-write table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded table survives a checker reset.
module mwc_exp_table #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int IW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_widx,
  input  logic [AW-1:0] i_wadr,
  input  logic [DW-1:0] i_wdata,
  input  logic [IW-1:0] i_ridx,
  output logic [AW-1:0] o_radr,
  output logic [DW-1:0] o_rdata
);

  logic [AW+DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we && (32'(i_widx) < DEPTH)) begin
      r_mem[i_widx] <= {i_wadr, i_wdata};
    end
  end

  assign {o_radr, o_rdata} = r_mem[i_ridx];

endmodule

// File: rtl/mem_write_checker.sv
// Compares a monitored memory write stream against a preloaded table of expected writes.
// Optional MWC_X_CHECK_EN: a RUN-state write carrying X/Z bits fails with code XVAL.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter int              DEPTH      = 4,
  parameter int              TIMEOUT    = 1000,
  parameter logic [AW-1:0]   IGNORE_ADR = AW'(96),
  parameter bit              IGNORE_EN  = 1'b1,
  localparam int             IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int             CW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [AW-1:0] exp_adr,
  input  logic [DW-1:0] exp_data,
  input  logic [CW-1:0] exp_count,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAdr,
  input  logic [DW-1:0] WriteData,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    fail_code,
  output logic [CW-1:0] match_count,
  output logic [IW-1:0] fail_idx
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        r_state, w_state_nxt;
  fail_code_t    r_code,  w_code_nxt;
  logic [IW-1:0] r_ptr,   w_ptr_nxt;
  logic [CW-1:0] r_mc,    w_mc_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [TW-1:0] r_cyc,   w_cyc_nxt;
  logic [IW-1:0] r_fidx,  w_fidx_nxt;
  logic          r_done,  w_done_nxt;
  logic          r_pass,  w_pass_nxt;
  logic          r_fail,  w_fail_nxt;

  logic [AW-1:0] w_radr;
  logic [DW-1:0] w_rdata;
  logic [TW-1:0] w_cyc_inc;
  logic          w_tmo, w_eval, w_hit, w_last, w_xbad;

  mwc_exp_table #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_table (
    .clk     (clk),
    .i_we    (exp_we && (r_state == ST_IDLE)),
    .i_widx  (exp_idx),
    .i_wadr  (exp_adr),
    .i_wdata (exp_data),
    .i_ridx  (r_ptr),
    .o_radr  (w_radr),
    .o_rdata (w_rdata)
  );

  assign w_cyc_inc = r_cyc + TW'(1);
  assign w_tmo     = (w_cyc_inc == TW'(TIMEOUT));
  assign w_eval    = MemWrite && !(IGNORE_EN && (DataAdr == IGNORE_ADR));
  assign w_hit     = (DataAdr == w_radr) && (WriteData == w_rdata);
  assign w_last    = (CW'(r_ptr) == (r_count - CW'(1)));

`ifdef MWC_X_CHECK_EN
  assign w_xbad = MemWrite && $isunknown({DataAdr, WriteData});
`else
  assign w_xbad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_code  <= FC_NONE;
      r_ptr   <= '0;
      r_mc    <= '0;
      r_count <= '0;
      r_cyc   <= '0;
      r_fidx  <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_ptr   <= w_ptr_nxt;
      r_mc    <= w_mc_nxt;
      r_count <= w_count_nxt;
      r_cyc   <= w_cyc_nxt;
      r_fidx  <= w_fidx_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_ptr_nxt   = r_ptr;
    w_mc_nxt    = r_mc;
    w_count_nxt = r_count;
    w_cyc_nxt   = r_cyc;
    w_fidx_nxt  = r_fidx;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_fail_nxt  = r_fail;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_count_nxt = exp_count;
          w_ptr_nxt   = '0;
          w_mc_nxt    = '0;
          w_cyc_nxt   = '0;
          if (exp_count == '0) begin
            w_state_nxt = ST_PASS;
            w_pass_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_cyc_nxt = w_cyc_inc;
        // Write evaluation outranks the timeout that may land on the same edge.
        if (w_xbad) begin
          w_state_nxt = ST_FAIL;
          w_fail_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_code_nxt  = FC_XVAL;
          w_fidx_nxt  = r_ptr;
        end else if (w_eval && w_hit) begin
          w_ptr_nxt = r_ptr + IW'(1);
          w_mc_nxt  = r_mc + CW'(1);
          if (w_last) begin
            w_state_nxt = ST_PASS;
            w_pass_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
          end else if (w_tmo) begin
            w_state_nxt = ST_FAIL;
            w_fail_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
            w_code_nxt  = FC_TIMEOUT;
            w_fidx_nxt  = r_ptr + IW'(1);
          end
        end else if (w_eval) begin
          w_state_nxt = ST_FAIL;
          w_fail_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_code_nxt  = FC_MISMATCH;
          w_fidx_nxt  = r_ptr;
        end else if (w_tmo) begin
          w_state_nxt = ST_FAIL;
          w_fail_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_code_nxt  = FC_TIMEOUT;
          w_fidx_nxt  = r_ptr;
        end
      end
      default: ;
    endcase
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign fail_code   = r_code;
  assign match_count = r_mc;
  assign fail_idx    = r_fidx;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker (TIMEOUT=20) with hand-computed expectations.
module tb_mem_write_checker;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int IW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset, start, exp_we, MemWrite;
  logic [IW-1:0] exp_idx;
  logic [AW-1:0] exp_adr, DataAdr;
  logic [DW-1:0] exp_data, WriteData;
  logic [CW-1:0] exp_count;
  logic          done, pass, fail;
  logic [1:0]    fail_code;
  logic [CW-1:0] match_count;
  logic [IW-1:0] fail_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_write_checker #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(20), .IGNORE_ADR(32'd96), .IGNORE_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_adr(exp_adr), .exp_data(exp_data), .exp_count(exp_count),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
    .match_count(match_count), .fail_idx(fail_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input int idx, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    exp_we = 1'b1; exp_idx = IW'(idx); exp_adr = adr; exp_data = dat;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic kick(input int cnt);
    start = 1'b1; exp_count = CW'(cnt);
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    MemWrite = 1'b1; DataAdr = adr; WriteData = dat;
    tick();
    MemWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exp_we = 1'b0; MemWrite = 1'b0;
    exp_idx = '0; exp_adr = '0; exp_data = '0; exp_count = '0;
    DataAdr = '0; WriteData = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_code", fail_code, 0);
    check("rst_mc", match_count, 0);
    check("rst_fidx", fail_idx, 0);

    // ignored address then a single matching write
    load(0, 32'd100, 32'd4096);
    kick(1);
    wr(32'd96, 32'd5);
    check("ign_pass", pass, 0);
    check("ign_mc", match_count, 0);
    wr(32'd100, 32'd4096);
    check("m1_pass", pass, 1);
    check("m1_fail", fail, 0);
    check("m1_done", done, 1);
    check("m1_mc", match_count, 1);
    wr(32'd5, 32'd5);
    tick();
    check("hold_pass", pass, 1);
    check("hold_fail", fail, 0);

    // table survives reset; data mismatch
    do_reset();
    check("rst2_pass", pass, 0);
    check("rst2_mc", match_count, 0);
    kick(1);
    wr(32'd100, 32'd7);
    check("mm_fail", fail, 1);
    check("mm_code", fail_code, 1);
    check("mm_fidx", fail_idx, 0);
    check("mm_pass", pass, 0);

    // timeout after exactly 20 RUN cycles
    do_reset();
    kick(1);
    for (int i = 0; i < 19; i++) tick();
    check("to_early", fail, 0);
    tick();
    check("to_fail", fail, 1);
    check("to_code", fail_code, 2);
    check("to_fidx", fail_idx, 0);

    // two entries: out-of-order write
    do_reset();
    load(0, 32'h10, 32'd1);
    load(1, 32'h14, 32'd2);
    kick(2);
    wr(32'h14, 32'd2);
    check("ooo_code", fail_code, 1);
    check("ooo_fidx", fail_idx, 0);

    // in order, final match lands on the timeout edge
    do_reset();
    kick(2);
    for (int i = 0; i < 18; i++) tick();
    wr(32'h10, 32'd1);
    check("edge_mc1", match_count, 1);
    check("edge_nf", fail, 0);
    wr(32'h14, 32'd2);
    check("edge_pass", pass, 1);
    check("edge_fail", fail, 0);
    check("edge_code", fail_code, 0);
    check("edge_mc2", match_count, 2);

    // mismatch on the second entry reports index 1
    do_reset();
    kick(2);
    wr(32'h10, 32'd1);
    wr(32'h14, 32'd3);
    check("mm1_code", fail_code, 1);
    check("mm1_fidx", fail_idx, 1);
    check("mm1_mc", match_count, 1);

    // reset mid-RUN, then count=0 restart
    do_reset();
    kick(2);
    wr(32'h10, 32'd1);
    check("mid_mc", match_count, 1);
    do_reset();
    check("mid_done", done, 0);
    check("mid_mc0", match_count, 0);
    kick(0);
    check("c0_pass", pass, 1);
    check("c0_done", done, 1);
    check("c0_mc", match_count, 0);

    // table writes outside IDLE are dropped
    load(0, 32'h99, 32'd0);
    do_reset();
    kick(1);
    wr(32'h10, 32'd1);
    check("we_ign_pass", pass, 1);

`ifdef MWC_X_CHECK_EN
    do_reset();
    kick(1);
    MemWrite = 1'b1; DataAdr = 32'h10; WriteData = 'x;
    tick();
    MemWrite = 1'b0; WriteData = '0;
    check("x_fail", fail, 1);
    check("x_code", fail_code, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
